// File: rtl/gcd_pkg.sv
// Shared constants and types for the multi-channel GCD accelerator:
// register map, status bit positions and the channel state encoding.
package gcd_pkg;

  localparam logic [3:0] OFF_A1 = 4'h0;
  localparam logic [3:0] OFF_A2 = 4'h4;
  localparam logic [3:0] OFF_W  = 4'h8;
  localparam logic [3:0] OFF_S  = 4'hC;
  localparam int CH_STRIDE = 16;

  localparam int S_DONE    = 0;
  localparam int S_ERR     = 1;
  localparam int S_OVR     = 2;
  localparam int S_BUSY    = 3;
  localparam int S_CNT_LSB = 16;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RUN
  } gcd_state_e;

endpackage

// File: rtl/gcd_core.sv
// One GCD channel: A1/A2/W/S registers plus a subtractive (MODE 0) or
// binary Stein (MODE 1) engine that advances one step per clock.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a1_we,
  input  logic             a2_we,
  input  logic             s_rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] w,
  output logic [31:0]      status
);

  localparam int KW = $clog2(WIDTH) + 1;

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, res;
  logic [KW-1:0]    k_q, k_nxt;
  logic [CNT_W-1:0] cnt;
  logic             done, err, ovr;
  logic             busy, start, zero_op, both_zero, fin;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign start = a2_we && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (MODE == 1) ? SHIFT : RUN;
      SHIFT:   if (zero_op) state_d = IDLE;
               else if (a_q[0] || b_q[0]) state_d = RUN;
      RUN:     if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    zero_op   = (a_q == '0) || (b_q == '0);
    both_zero = (a_q == '0) && (b_q == '0);
    fin       = ((state_q == RUN) && (zero_op || (a_q == b_q))) ||
                ((state_q == SHIFT) && zero_op);
    // k stays 0 in MODE 0, so the shift is a no-op there
    res       = zero_op ? (a_q | b_q) : (a_q << k_q);
    status    = '0;
    status[S_DONE] = done;
    status[S_ERR]  = err;
    status[S_OVR]  = ovr;
    status[S_BUSY] = busy;
    status[S_CNT_LSB +: CNT_W] = cnt;
  end

  // After SHIFT at most one operand is even, and an odd-odd difference is
  // halved immediately, so every RUN step drops at least one operand bit.
  always_comb begin
    a_nxt = a_q;
    b_nxt = b_q;
    k_nxt = k_q;
    if (state_q == SHIFT) begin
      if (!zero_op && !a_q[0] && !b_q[0]) begin
        a_nxt = a_q >> 1;
        b_nxt = b_q >> 1;
        k_nxt = k_q + 1'b1;
      end
    end else if (state_q == RUN && !fin) begin
      if (MODE == 0) begin
        if (a_q < b_q) b_nxt = b_q - a_q;
        else           a_nxt = a_q - b_q;
      end else if (!a_q[0]) begin
        a_nxt = a_q >> 1;
      end else if (!b_q[0]) begin
        b_nxt = b_q >> 1;
      end else if (a_q > b_q) begin
        a_nxt = (a_q - b_q) >> 1;
      end else begin
        b_nxt = (b_q - a_q) >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1   <= '0;
      a2   <= '0;
      w    <= '0;
      a_q  <= '0;
      b_q  <= '0;
      k_q  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (a1_we) a1 <= wdata;
      if (start) begin
        a2   <= wdata;
        a_q  <= a1;
        b_q  <= wdata;
        k_q  <= '0;
        cnt  <= '0;
        done <= 1'b0;
        err  <= 1'b0;
        ovr  <= 1'b0;
      end else begin
        if (a2_we) ovr <= 1'b1;
        if (busy) begin
          cnt <= sat_inc(cnt);
          a_q <= a_nxt;
          b_q <= b_nxt;
          k_q <= k_nxt;
        end
        // completion beats a coincident status read
        if (fin) begin
          w    <= res;
          err  <= both_zero;
          done <= 1'b1;
        end else if (s_rd) begin
          done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_accel_mc.sv
// Multi-channel GCD accelerator on the CPU slave bus: address decode,
// NCH independent channels, registered read data and a level interrupt.
module gcd_accel_mc
  import gcd_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int          NCH   = 2,
  parameter logic [15:0] BASE  = 16'h00F8,
  parameter int          MODE  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        irq
);

  logic [15:0]      off;
  logic             hit;
  logic [1:0]       ch;
  logic [3:0]       rg;
  logic [31:0]      rd_word;
  logic [WIDTH-1:0] a1_v [NCH];
  logic [WIDTH-1:0] a2_v [NCH];
  logic [WIDTH-1:0] w_v  [NCH];
  logic [31:0]      s_v  [NCH];
  logic [NCH-1:0]   done_v;
  logic             unused_hi;

  // Addresses below BASE wrap to large offsets and fall outside the window.
  assign off = saddress - BASE;
  assign hit = off < 16'(NCH * CH_STRIDE);
  assign ch  = off[5:4];
  assign rg  = off[3:0];
  assign unused_hi = ^sdata_in;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = hit && (ch == 2'(i));

    gcd_core #(
      .WIDTH(WIDTH),
      .MODE (MODE)
    ) u_core (
      .clk   (clk),
      .reset (reset),
      .a1_we (swr && sel && (rg == OFF_A1)),
      .a2_we (swr && sel && (rg == OFF_A2)),
      .s_rd  (srd && sel && (rg == OFF_S)),
      .wdata (sdata_in[WIDTH-1:0]),
      .a1    (a1_v[i]),
      .a2    (a2_v[i]),
      .w     (w_v[i]),
      .status(s_v[i])
    );

    assign done_v[i] = s_v[i][S_DONE];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit && (ch == 2'(i))) begin
        case (rg)
          OFF_A1:  rd_word = 32'(a1_v[i]);
          OFF_A2:  rd_word = 32'(a2_v[i]);
          OFF_W:   rd_word = 32'(w_v[i]);
          OFF_S:   rd_word = s_v[i];
          default: rd_word = '0;
        endcase
      end
    end
  end

  // Read data is captured from pre-edge register state and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sdata_out <= '0;
    else if (srd) sdata_out <= rd_word;
  end

  assign irq = |done_v;

endmodule

// File: tb/tb_gcd_accel_mc.sv
// Bench for gcd_accel_mc: three instances share one bus (MODE 0/WIDTH 32,
// MODE 1/WIDTH 16, MODE 0/WIDTH 8); the first is tracked by a reference model.
module tb_gcd_accel_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [15:0] saddress = '0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out0, sdata_out1, sdata_out2;
  logic        irq0, irq1, irq2;
  int          checks = 0;
  int          errors = 0;

  localparam logic [15:0] CH0 = 16'h00F8;
  localparam logic [15:0] CH1 = 16'h0108;

  always #5 clk = ~clk;

  gcd_accel_mc u_dut0 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out0), .irq(irq0)
  );
  gcd_accel_mc #(.WIDTH(16), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out1), .irq(irq1)
  );
  gcd_accel_mc #(.WIDTH(8)) u_dut2 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out2), .irq(irq2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of u_dut0 (2 channels, 32-bit, subtractive Euclid)
  logic [31:0] m_a1 [2], m_a2 [2], m_w [2], m_res [2];
  logic        m_done [2], m_err [2], m_ovr [2], m_busy [2], m_rerr [2];
  int          m_cnt [2], m_rem [2];
  logic [31:0] m_rdata;

  task automatic m_clear();
    for (int c = 0; c < 2; c++) begin
      m_a1[c] = 0; m_a2[c] = 0; m_w[c] = 0; m_res[c] = 0;
      m_done[c] = 0; m_err[c] = 0; m_ovr[c] = 0; m_busy[c] = 0; m_rerr[c] = 0;
      m_cnt[c] = 0; m_rem[c] = 0;
    end
    m_rdata = 0;
  endtask

  function automatic int m_off(input logic [15:0] addr);
    int off;
    off = int'(addr) - 248;
    return (off < 0 || off >= 32) ? -1 : off;
  endfunction

  function automatic logic [31:0] m_status(input int c);
    int sat;
    sat = (m_cnt[c] > 65535) ? 65535 : m_cnt[c];
    return {sat[15:0], 12'd0, m_busy[c], m_ovr[c], m_err[c], m_done[c]};
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] addr);
    int off;
    off = m_off(addr);
    if (off < 0) return 0;
    case (off % 16)
      0:       return m_a1[off / 16];
      4:       return m_a2[off / 16];
      8:       return m_w[off / 16];
      12:      return m_status(off / 16);
      default: return 0;
    endcase
  endfunction

  // Cycle count of subtractive Euclid = sum of the division quotients
  // (the last quotient's final subtraction is replaced by the a==b cycle).
  task automatic m_gcd(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] g, output logic e, output int steps);
    logic [31:0] x, y;
    x = a; y = b; steps = 0;
    while (x != 0 && y != 0) begin
      if (x >= y) begin steps += int'(x / y); x = x % y; end
      else        begin steps += int'(y / x); y = y % x; end
    end
    g = x | y;
    e = (a == 0) && (b == 0);
    if (a == 0 || b == 0) steps = 1;
  endtask

  task automatic m_edge();
    logic [31:0] rd;
    logic        pre_busy [2];
    int          off, c;
    rd = m_read(saddress);
    for (int i = 0; i < 2; i++) pre_busy[i] = m_busy[i];
    off = m_off(saddress);
    if (srd && off >= 0 && (off % 16) == 12) m_done[off / 16] = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i]) begin
        m_cnt[i]++;
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_busy[i] = 0; m_done[i] = 1; m_w[i] = m_res[i]; m_err[i] = m_rerr[i];
        end
      end
    end
    if (swr && off >= 0) begin
      c = off / 16;
      if ((off % 16) == 0) m_a1[c] = sdata_in;
      else if ((off % 16) == 4) begin
        if (pre_busy[c]) m_ovr[c] = 1;
        else begin
          m_a2[c] = sdata_in;
          m_gcd(m_a1[c], sdata_in, m_res[c], m_rerr[c], m_rem[c]);
          m_busy[c] = 1; m_done[c] = 0; m_err[c] = 0; m_ovr[c] = 0; m_cnt[c] = 0;
        end
      end
    end
    if (srd) m_rdata = rd;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_clear();
      else       m_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_rdata", sdata_out0, m_rdata);
    chk("model_irq", 32'(irq0), 32'(m_done[0] | m_done[1]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic bus_wr(input logic [15:0] addr, input logic [31:0] d);
    saddress = addr; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr);
    saddress = addr; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    chk("rst_rdata", sdata_out0, 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    reset = 1'b0;

    // 48/18 subtractive: 30,12,(b)6,6,equal -> 5 cycles, W=6
    bus_wr(CH0, 32'd48);
    bus_wr(CH0 + 16'h4, 32'd18);
    bus_rd(CH0 + 16'hC);
    chk("m0_busy", sdata_out0, 32'h0000_0008);
    idle(4);
    bus_rd(CH0 + 16'h8);
    chk("m0_w", sdata_out0, 32'd6);
    chk("m0_irq_set", 32'(irq0), 32'h1);
    bus_rd(CH0 + 16'hC);
    chk("m0_s_done", sdata_out0, 32'h0005_0001);
    bus_rd(CH0 + 16'hC);
    chk("m0_s_clr", sdata_out0, 32'h0005_0000);
    chk("m0_irq_clr", 32'(irq0), 32'h0);

    // gcd(61440, 3072) = 3072
    bus_wr(CH0, 32'h0000_F000);
    bus_wr(CH0 + 16'h4, 32'h0000_0C00);
    idle(34);
    bus_rd(CH0 + 16'hC);
    chk("m1_s_a", sdata_out1 & 32'hF, 32'h1);
    chk("m1_cnt_a", 32'(sdata_out1[31:16] <= 16'd34), 32'h1);
    bus_rd(CH0 + 16'h8);
    chk("m1_w_a", sdata_out1, 32'h0000_0C00);
    chk("m0_w_a", sdata_out0, 32'h0000_0C00);

    bus_wr(CH1, 32'd17);
    bus_wr(CH1 + 16'h4, 32'd5);
    idle(34);
    bus_rd(CH1 + 16'hC);
    chk("m1_s_b", sdata_out1 & 32'hF, 32'h1);
    chk("m1_cnt_b", 32'(sdata_out1[31:16] <= 16'd34), 32'h1);
    bus_rd(CH1 + 16'h8);
    chk("m1_w_b", sdata_out1, 32'd1);
    chk("m0_w_b", sdata_out0, 32'd1);

    // zero operands
    bus_wr(CH0, 32'd0);
    bus_wr(CH0 + 16'h4, 32'd35);
    idle(2);
    bus_rd(CH0 + 16'h8);
    chk("z1_w", sdata_out0, 32'd35);
    chk("z1_w_m1", sdata_out1, 32'd35);
    bus_rd(CH0 + 16'hC);
    chk("z1_s", sdata_out0, 32'h0001_0001);
    chk("z1_s_m1", sdata_out1, 32'h0001_0001);
    bus_wr(CH0 + 16'h4, 32'd0);
    idle(2);
    bus_rd(CH0 + 16'hC);
    chk("z2_s", sdata_out0, 32'h0001_0003);
    chk("z2_s_m1", sdata_out1, 32'h0001_0003);
    bus_rd(CH0 + 16'h8);
    chk("z2_w", sdata_out0, 32'd0);

    // overlap: ch0 1000/3 takes 333+3 = 336 cycles; ch1 21/14 runs alongside
    bus_wr(CH0, 32'd1000);
    bus_wr(CH0 + 16'h4, 32'd3);
    bus_wr(CH1, 32'd21);
    bus_wr(CH1 + 16'h4, 32'd14);
    idle(3);
    bus_wr(CH0 + 16'h4, 32'd7);
    bus_wr(CH0, 32'd99);
    bus_rd(CH0 + 16'hC);
    chk("ov_s", sdata_out0 & 32'hF, 32'hC);
    bus_rd(CH0 + 16'h4);
    chk("ov_a2", sdata_out0, 32'd3);
    bus_rd(CH1 + 16'h8);
    chk("ov_w1", sdata_out0, 32'd7);
    idle(340);
    bus_rd(CH0 + 16'h8);
    chk("ov_w0", sdata_out0, 32'd1);
    bus_rd(CH0 + 16'hC);
    chk("ov_s_end", sdata_out0, 32'h0150_0005);

    // reset while ch0 is busy
    bus_wr(CH0, 32'd1000);
    bus_wr(CH0 + 16'h4, 32'd3);
    idle(3);
    bus_rd(CH0);
    chk("pre_rst_a1", sdata_out0, 32'd1000);
    chk("pre_rst_irq", 32'(irq0), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_rdata", sdata_out0, 32'h0);
    chk("rst_mid_irq", 32'(irq0), 32'h0);
    chk("rst_mid_rdata_m1", sdata_out1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(CH0 + 16'hC);
    chk("post_rst_s", sdata_out0, 32'h0);
    bus_rd(CH0 + 16'h4);
    chk("post_rst_a2", sdata_out0, 32'h0);
    bus_wr(CH0, 32'd48);
    bus_wr(CH0 + 16'h4, 32'd18);
    idle(6);
    bus_rd(CH0 + 16'h8);
    chk("post_rst_w", sdata_out0, 32'd6);

    // bus edges
    bus_rd(CH0 + 16'h20);
    chk("unmapped", sdata_out0, 32'h0);
    saddress = CH0; sdata_in = 32'h0000_1234; srd = 1'b1; swr = 1'b1;
    @(negedge clk);
    srd = 1'b0; swr = 1'b0;
    chk("rw_old", sdata_out0, 32'd48);
    bus_rd(CH0);
    chk("rw_new", sdata_out0, 32'h0000_1234);
    chk("w8_trunc", sdata_out2, 32'h0000_0034);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
